bfs_csr_builder: RTL and testbench

- Upstream feeder for the BFS kernel: converts a streamed, source-sorted edge list (src, dst) into the CSR node and edge tables that BFS reads.
- Per node, writes a begin/end edge-offset pair into the node table; per edge, writes the destination into the edge table.
- Fills trailing empty nodes, then pulses done; flags malformed input with err.

---
 rtl/bfs_pkg.sv | 22 ++
 rtl/bfs_csr_builder.sv | 142 ++++++++++++++
 tb/tb_bfs_csr_builder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bfs_pkg.sv
// Shared graph geometry and record types for the CSR builder and the BFS kernel.
package bfs_pkg;

    localparam int N_NODES = 16;
    localparam int N_EDGES = 16;
    localparam int NODE_W  = $clog2(N_NODES);
    localparam int EIDX_W  = $clog2(N_EDGES) + 1;

    typedef struct packed {
        logic [EIDX_W-1:0] begin_off;
        logic [EIDX_W-1:0] end_off;
    } node_rec;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DONE,
        ST_ERR
    } build_state_e;

endpackage

// File: rtl/bfs_csr_builder.sv
// Builds CSR node/edge tables from a source-sorted edge stream; one table write per cycle.
module bfs_csr_builder
    import bfs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NODE_W-1:0] in_src,
    input  logic [NODE_W-1:0] in_dst,
    input  logic              in_last,
    output logic              node_we,
    output logic [NODE_W-1:0] node_addr,
    output logic [EIDX_W-1:0] node_begin,
    output logic [EIDX_W-1:0] node_end,
    output logic              edge_we,
    output logic [EIDX_W-2:0] edge_addr,
    output logic [NODE_W-1:0] edge_dst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [NODE_W:0]   NODE_LIMIT = (NODE_W+1)'(N_NODES);
    localparam logic [NODE_W-1:0] LAST_NODE  = NODE_W'(N_NODES - 1);
    localparam logic [EIDX_W-1:0] EDGE_CAP   = EIDX_W'(N_EDGES);

    build_state_e      state, state_n;
    logic [NODE_W-1:0] cur_node, cur_node_n;
    logic [EIDX_W-1:0] nbegin, nbegin_n;
    logic [EIDX_W-1:0] ecount, ecount_n;

    logic              node_we_n, edge_we_n;
    logic [NODE_W-1:0] node_addr_n;
    node_rec           node_rec_q, node_rec_n;
    logic [EIDX_W-2:0] edge_addr_n;
    logic [NODE_W-1:0] edge_dst_n;
    logic              src_bad;

    // Malformed input: out-of-range source, source going backwards, or table already full.
    assign src_bad = ({1'b0, in_src} >= NODE_LIMIT) || (in_src < cur_node) || (ecount == EDGE_CAP);

    always_comb begin
        state_n     = state;
        cur_node_n  = cur_node;
        nbegin_n    = nbegin;
        ecount_n    = ecount;
        node_we_n   = 1'b0;
        node_addr_n = node_addr;
        node_rec_n  = node_rec_q;
        edge_we_n   = 1'b0;
        edge_addr_n = edge_addr;
        edge_dst_n  = edge_dst;
        in_ready    = 1'b0;

        case (state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_n    = ST_LOAD;
                    cur_node_n = '0;
                    nbegin_n   = '0;
                    ecount_n   = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (src_bad) begin
                        state_n = ST_ERR;
                    end else if (in_src > cur_node) begin
                        // Close out the current node and step toward in_src while the edge waits.
                        node_we_n   = 1'b1;
                        node_addr_n = cur_node;
                        node_rec_n  = '{begin_off: nbegin, end_off: ecount};
                        nbegin_n    = ecount;
                        cur_node_n  = cur_node + NODE_W'(1);
                    end else begin
                        in_ready    = 1'b1;
                        edge_we_n   = 1'b1;
                        edge_addr_n = ecount[EIDX_W-2:0];
                        edge_dst_n  = in_dst;
                        ecount_n    = ecount + EIDX_W'(1);
                        if (in_last) begin
                            state_n = ST_FILL;
                        end
                    end
                end
            end
            ST_FILL: begin
                // After the first fill write nbegin tracks ecount, so trailing nodes come out empty.
                node_we_n   = 1'b1;
                node_addr_n = cur_node;
                node_rec_n  = '{begin_off: nbegin, end_off: ecount};
                nbegin_n    = ecount;
                if (cur_node == LAST_NODE) begin
                    state_n = ST_DONE;
                end else begin
                    cur_node_n = cur_node + NODE_W'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_node   <= '0;
            nbegin     <= '0;
            ecount     <= '0;
            node_we    <= 1'b0;
            node_addr  <= '0;
            node_rec_q <= '0;
            edge_we    <= 1'b0;
            edge_addr  <= '0;
            edge_dst   <= '0;
        end else begin
            state      <= state_n;
            cur_node   <= cur_node_n;
            nbegin     <= nbegin_n;
            ecount     <= ecount_n;
            node_we    <= node_we_n;
            node_addr  <= node_addr_n;
            node_rec_q <= node_rec_n;
            edge_we    <= edge_we_n;
            edge_addr  <= edge_addr_n;
            edge_dst   <= edge_dst_n;
        end
    end

    assign node_begin = node_rec_q.begin_off;
    assign node_end   = node_rec_q.end_off;
    assign busy       = (state == ST_LOAD) || (state == ST_FILL);
    assign done       = (state == ST_DONE);
    assign err        = (state == ST_ERR);

endmodule

// File: tb/tb_bfs_csr_builder.sv
// Self-checking bench for bfs_csr_builder: directed corner cases plus randomized sorted graphs.
module tb_bfs_csr_builder;
    import bfs_pkg::*;

    logic              clk = 1'b0;
    logic              rst, start, in_valid, in_last;
    logic              in_ready;
    logic [NODE_W-1:0] in_src, in_dst;
    logic              node_we, edge_we, busy, done, err;
    logic [NODE_W-1:0] node_addr, edge_dst;
    logic [EIDX_W-1:0] node_begin, node_end;
    logic [EIDX_W-2:0] edge_addr;

    always #5 clk = ~clk;

    bfs_csr_builder dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_dst(in_dst), .in_last(in_last),
        .node_we(node_we), .node_addr(node_addr), .node_begin(node_begin), .node_end(node_end),
        .edge_we(edge_we), .edge_addr(edge_addr), .edge_dst(edge_dst),
        .busy(busy), .done(done), .err(err)
    );

    // Write capture: only this block writes the logs and event counters.
    logic [NODE_W+2*EIDX_W-1:0] node_log[$];
    logic [EIDX_W-1+NODE_W-1:0] edge_log[$];
    int done_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (node_we) node_log.push_back({node_addr, node_begin, node_end});
        if (edge_we) edge_log.push_back({edge_addr, edge_dst});
        if (node_we && edge_we) both_cnt++;
        if (done) done_cnt++;
    end

    int total = 0;
    int pass_cnt = 0;
    int q_src[$];
    int q_dst[$];
    int ns, es, ds, bs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic snap();
        ns = node_log.size();
        es = edge_log.size();
        ds = done_cnt;
        bs = both_cnt;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_edge(input int s, input int d, input bit last, input int max_wait, output bit acc);
        in_valid = 1'b1;
        in_src   = NODE_W'(s);
        in_dst   = NODE_W'(d);
        in_last  = last;
        acc      = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference CSR: begin(n) = edges with src < n, end(n) = edges with src <= n.
    function automatic logic [2*EIDX_W-1:0] model_node(input int n);
        int b = 0;
        int e = 0;
        foreach (q_src[i]) begin
            if (q_src[i] < n) b++;
            if (q_src[i] <= n) e++;
        end
        return {EIDX_W'(b), EIDX_W'(e)};
    endfunction

    task automatic check_node_table(input string tag, input int first_node, input int n_nodes);
        logic [2*EIDX_W-1:0] tab[N_NODES];
        logic [NODE_W-1:0]   a;
        logic [EIDX_W-1:0]   b, e;
        foreach (tab[i]) tab[i] = 'x;
        for (int i = ns; i < node_log.size(); i++) begin
            {a, b, e} = node_log[i];
            tab[a] = {b, e};
        end
        check({tag, "_node_writes"}, node_log.size() - ns, n_nodes);
        for (int n = first_node; n < first_node + n_nodes; n++)
            check($sformatf("%s_node%0d", tag, n), tab[n], model_node(n));
    endtask

    task automatic check_edge_table(input string tag);
        logic [EIDX_W-2:0] ea;
        logic [NODE_W-1:0] ed;
        check({tag, "_edge_writes"}, edge_log.size() - es, q_dst.size());
        for (int i = 0; i < q_dst.size() && es + i < edge_log.size(); i++) begin
            ea = (EIDX_W-1)'(i);
            ed = NODE_W'(q_dst[i]);
            check($sformatf("%s_edge%0d", tag, i), edge_log[es+i], {ea, ed});
        end
    endtask

    task automatic run_build(input string tag, input bit gaps);
        bit acc;
        int n_acc = 0;
        snap();
        pulse_start();
        for (int i = 0; i < q_src.size(); i++) begin
            send_edge(q_src[i], q_dst[i], i == q_src.size() - 1, 40, acc);
            if (acc) n_acc++;
            if (gaps) begin
                @(posedge clk); #1;
            end
        end
        check({tag, "_accepted"}, n_acc, q_src.size());
        for (int i = 0; i < 60 && done_cnt == ds; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, done_cnt - ds, 1);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_we_overlap"}, both_cnt - bs, 0);
        check_node_table(tag, 0, N_NODES);
        check_edge_table(tag);
    endtask

    task automatic load_basic();
        q_src = '{0, 0, 2};
        q_dst = '{1, 2, 3};
    endtask

    initial begin
        bit acc;
        int n, tmp_ns, tmp_es;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_src = '0; in_dst = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {in_ready, node_we, node_addr, node_begin, node_end, edge_we, edge_addr, edge_dst, busy, done, err}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        load_basic();
        run_build("basic", 1'b0);
        run_build("gaps", 1'b1);

        // Unsorted source: node 3 stalls out n0..n2, then source 1 goes backwards.
        snap();
        q_src = '{3};
        q_dst = '{1};
        pulse_start();
        send_edge(3, 1, 1'b0, 20, acc);
        check("unsorted_first_acc", acc, 1'b1);
        send_edge(1, 2, 1'b1, 6, acc);
        check("unsorted_second_acc", acc, 1'b0);
        check("unsorted_err", err, 1'b1);
        check("unsorted_busy", busy, 1'b0);
        check_node_table("unsorted", 0, 3);
        check_edge_table("unsorted");
        tmp_ns = node_log.size(); tmp_es = edge_log.size();
        repeat (5) @(posedge clk);
        #1;
        check("unsorted_quiet", (node_log.size() - tmp_ns) + (edge_log.size() - tmp_es), 0);
        check("unsorted_err_sticky", err, 1'b1);
        pulse_start();
        check("restart_err_clear", err, 1'b0);
        check("restart_busy", busy, 1'b1);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        load_basic();
        run_build("after_err", 1'b0);

        // Overflow: 17 edges from node 0.
        snap();
        q_src.delete(); q_dst.delete();
        for (int i = 0; i < N_EDGES; i++) begin
            q_src.push_back(0);
            q_dst.push_back($urandom_range(0, N_NODES - 1));
        end
        pulse_start();
        n = 0;
        foreach (q_src[i]) begin
            send_edge(0, q_dst[i], 1'b0, 10, acc);
            if (acc) n++;
        end
        check("ovf_accepted", n, N_EDGES);
        send_edge(0, 5, 1'b0, 6, acc);
        check("ovf_17th_acc", acc, 1'b0);
        check("ovf_err", err, 1'b1);
        check_edge_table("ovf");
        check("ovf_node_writes", node_log.size() - ns, 0);

        // Exactly N_EDGES with last: legal, restarted straight from ERR.
        run_build("full16", 1'b0);

        q_src = '{15};
        q_dst = '{0};
        run_build("last_node", 1'b0);

        // Reset mid-LOAD after two accepted edges.
        pulse_start();
        send_edge(0, 1, 1'b0, 10, acc);
        send_edge(0, 2, 1'b0, 10, acc);
        check("midrst_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_outputs",
              {in_ready, node_we, node_addr, node_begin, node_end, edge_we, edge_addr, edge_dst, busy, done, err}, 0);
        rst = 1'b0;
        snap();
        in_valid = 1'b1; in_src = 4'd0; in_dst = 4'd7;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_idle_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        check("midrst_no_writes", (node_log.size() - ns) + (edge_log.size() - es), 0);
        load_basic();
        run_build("after_rst", 1'b0);

        // Randomized sorted graphs, optional idle gaps.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, N_EDGES);
            q_src.delete(); q_dst.delete();
            for (int i = 0; i < n; i++) begin
                q_src.push_back($urandom_range(0, N_NODES - 1));
                q_dst.push_back($urandom_range(0, N_NODES - 1));
            end
            q_src.sort();
            run_build($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
